ofm_writeback: RTL

//  Write-side counterpart of the conv datapath's read path. Captures the 16 x 8-bit OFM channel bytes
//  the PE cluster presents with valid, buffers them, packs them into 32-bit words and drives the
//  OFM BRAM write port (wr_addr / wr_en / data) with generated addresses.

---
 rtl/ofm_writeback_if.sv | 33 +++
 rtl/ofm_writeback.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback_if.sv
// Bus between the PE-cluster output stage, the OFM writeback block and the
// OFM BRAM write port: layer config and start, beat input with back-pressure,
// BRAM write strobe/address/data, and layer status.
interface ofm_writeback_if #(
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 16
);
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [7:0]            ofm_w;
  logic [7:0]            ofm_c;
  logic                  valid_in;
  logic [NUM_CH*8-1:0]   ofm_in;
  logic                  full;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  // Upstream / controller side.
  modport master (
    output start, base_addr, ofm_w, ofm_c, valid_in, ofm_in,
    input  full, wr_en, wr_addr, wr_data, busy, done, overflow
  );

  // Writeback block side.
  modport slave (
    input  start, base_addr, ofm_w, ofm_c, valid_in, ofm_in,
    output full, wr_en, wr_addr, wr_data, busy, done, overflow
  );
endinterface

// File: rtl/ofm_writeback.sv
// OFM writeback: buffers 128-bit PE-cluster beats in a small FIFO, splits each
// beat into four 32-bit words and writes them to the OFM BRAM at addresses
// generated from (pixel, tile, word) counters. Signals completion per layer.
module ofm_writeback #(
  parameter int NUM_CH = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  ofm_writeback_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = NUM_CH * 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [15:0]        pix_last_q, pix_last_d;
  logic [15:0]        pix_q, pix_d;
  logic [3:0]         tile_last_q, tile_last_d;
  logic [3:0]         tile_q, tile_d;
  logic [5:0]         stride_q, stride_d;
  logic [1:0]         k_q, k_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic [BEAT_W-1:0]  mem_q [DEPTH];

  logic               wr_en;
  logic               pop;
  logic               push;
  logic               cfg_empty;
  logic               last_word;
  logic [BEAT_W-1:0]  head;

  // Next-state, FIFO bookkeeping and address counters.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d     = state_q;
    base_d      = base_q;
    pix_last_d  = pix_last_q;
    pix_d       = pix_q;
    tile_last_d = tile_last_q;
    tile_d      = tile_q;
    stride_d    = stride_q;
    k_d         = k_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    wr_en     = (state_q == S_RUN) && (count_q != '0);
    pop       = wr_en && (k_q == 2'd3);
    push      = (state_q == S_RUN) && bus.valid_in && (!full_q || pop);
    cfg_empty = (bus.ofm_w == 8'd0) || (bus.ofm_c < 8'd16);
    last_word = pop && (pix_q == pix_last_q) && (tile_q == tile_last_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d      = bus.base_addr;
          pix_last_d  = 16'(bus.ofm_w) * 16'(bus.ofm_w) - 16'd1;
          tile_last_d = bus.ofm_c[7:4] - 4'd1;
          stride_d    = bus.ofm_c[7:2];
          pix_d       = '0;
          tile_d      = '0;
          k_d         = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          state_d     = cfg_empty ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (wr_en) k_d = k_q + 2'd1;
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (pix_q == pix_last_q) begin
            pix_d  = '0;
            tile_d = tile_q + 4'd1;
          end else begin
            pix_d  = pix_q + 16'd1;
          end
        end
        // A push and a pop on the same edge leave the occupancy unchanged.
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (bus.valid_in && full_q && !pop) overflow_d = 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    full_d = (count_d == CNT_W'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Config, counters, FIFO pointers and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      pix_last_q  <= '0;
      pix_q       <= '0;
      tile_last_q <= '0;
      tile_q      <= '0;
      stride_q    <= '0;
      k_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      base_q      <= base_d;
      pix_last_q  <= pix_last_d;
      pix_q       <= pix_d;
      tile_last_q <= tile_last_d;
      tile_q      <= tile_d;
      stride_q    <= stride_d;
      k_q         <= k_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Beat storage written on push.
  always_ff @(posedge clk) begin
    // NOTE: storage array has no reset; occupancy is tracked by count_q, so stale contents are never read.
    if (push) mem_q[wr_ptr_q] <= bus.ofm_in;
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.wr_en    = wr_en;
  assign bus.wr_data  = wr_en ? head[{k_q, 5'd0} +: 32] : 32'd0;
  assign bus.wr_addr  = wr_en ? (base_q + ADDR_W'(pix_q) * ADDR_W'(stride_q)
                                 + ADDR_W'({tile_q, 2'b00}) + ADDR_W'(k_q))
                              : '0;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

endmodule
